// File: rtl/bcd_stopwatch_core_pkg.sv
// Shared types and helpers for the BCD stopwatch core.
package bcd_stopwatch_core_pkg;

    // Control states of the stopwatch.
    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StPause,
        StDone
    } sw_state_t;

    localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;

    // Clamp an out-of-range digit to the largest legal value for its modulus.
    function automatic logic [3:0] bcd_sanitise(input logic [3:0] digit,
                                                input logic [3:0] modulus);
        if (digit >= modulus) begin
            return modulus - 4'd1;
        end
        return digit;
    endfunction

endpackage

// File: rtl/bcd_stopwatch_core_if.sv
// Control/status bundle between the pushbutton front end and the stopwatch core.
interface bcd_stopwatch_core_if #(
    parameter int unsigned N_DIGITS = 4
);
    logic                    start_stop;
    logic                    clear;
    logic                    load;
    logic                    dir;
    logic                    lap;
    logic [4*N_DIGITS-1:0]   load_value;
    logic [4*N_DIGITS-1:0]   count;
    logic [4*N_DIGITS-1:0]   disp;
    logic                    running;
    logic                    done;
    logic                    wrap;
    logic                    tick;

    modport master (
        output start_stop, clear, load, dir, lap, load_value,
        input  count, disp, running, done, wrap, tick
    );

    modport slave (
        input  start_stop, clear, load, dir, lap, load_value,
        output count, disp, running, done, wrap, tick
    );
endinterface

// File: rtl/bcd_stopwatch_core_digit.sv
// One BCD digit with programmable modulus, ripple carry/borrow and synchronous load.
module bcd_stopwatch_core_digit #(
    parameter logic [3:0] MOD = 4'd10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       inc,
    input  logic       dec,
    input  logic       load,
    input  logic [3:0] load_value,
    output logic [3:0] value,
    output logic       carry,
    output logic       borrow
);

    logic [3:0] value_q;
    logic       at_top;
    logic       at_zero;

    assign at_top  = (value_q == MOD - 4'd1);
    assign at_zero = (value_q == 4'd0);

    // Carry/borrow only ripple when this digit is actually stepping past its end.
    assign carry  = en & inc & at_top;
    assign borrow = en & dec & at_zero;
    assign value  = value_q;

    // Digit register: load overrides stepping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q <= 4'd0;
        end else if (load) begin
            value_q <= load_value;
        end else if (en && inc) begin
            value_q <= at_top ? 4'd0 : value_q + 4'd1;
        end else if (en && dec) begin
            value_q <= at_zero ? MOD - 4'd1 : value_q - 4'd1;
        end
    end

endmodule

// File: rtl/bcd_stopwatch_core.sv
// N-digit BCD stopwatch/timer: tick divider, run control FSM, lap hold and wrap/done logic.
module bcd_stopwatch_core
    import bcd_stopwatch_core_pkg::*;
#(
    parameter int unsigned N_DIGITS      = 4,
    parameter int unsigned TICK_DIV      = 1000000,
    parameter int unsigned TOP_DIGIT_MOD = 6,
    parameter bit          WRAP_EN       = 1'b1
) (
    input  logic                   clk100,
    input  logic                   reset_n,
    bcd_stopwatch_core_if.slave    bus
);

    localparam int unsigned W     = 4 * N_DIGITS;
    localparam int unsigned DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

    sw_state_t          state_q, state_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic               lap_hold_q, lap_hold_d;
    logic [W-1:0]       snap_q, snap_d;
    logic               wrap_q;

    logic [W-1:0]          count_w;
    logic [W-1:0]          load_clean;
    logic [W-1:0]          ld_val;
    logic                  ld;
    logic                  step_up;
    logic                  step_dn;
    logic [N_DIGITS-1:0]   digit_en;
    logic [N_DIGITS-1:0]   carry;
    logic [N_DIGITS-1:0]   borrow;
    logic [N_DIGITS-1:0]   digit_max;
    logic                  at_max;
    logic                  is_zero;
    logic                  is_one;
    logic                  tick_now;

    // A borrow out of the top digit cannot happen: a down-step is never issued at zero.
    logic unused_borrow;
    assign unused_borrow = borrow[N_DIGITS-1];

    for (genvar i = 0; i < N_DIGITS; i++) begin : g_digit
        localparam logic [3:0] DigitMod = (i == N_DIGITS - 1) ? 4'(TOP_DIGIT_MOD)
                                                              : BCD_MAX_DIGIT + 4'd1;
        if (i == 0) begin : g_lsd
            assign digit_en[i] = step_up | step_dn;
        end else begin : g_ripple
            assign digit_en[i] = carry[i-1] | borrow[i-1];
        end

        assign load_clean[4*i +: 4] = bcd_sanitise(bus.load_value[4*i +: 4], DigitMod);
        assign digit_max[i]         = (count_w[4*i +: 4] == DigitMod - 4'd1);

        bcd_stopwatch_core_digit #(
            .MOD (DigitMod)
        ) u_digit (
            .clk        (clk100),
            .rst_n      (reset_n),
            .en         (digit_en[i]),
            .inc        (step_up),
            .dec        (step_dn),
            .load       (ld),
            .load_value (ld_val[4*i +: 4]),
            .value      (count_w[4*i +: 4]),
            .carry      (carry[i]),
            .borrow     (borrow[i])
        );
    end

    assign at_max   = &digit_max;
    assign is_zero  = (count_w == '0);
    assign is_one   = (count_w == W'(1));
    assign tick_now = (state_q == StRun) && (div_q == DIV_LAST);

    // Next-state, divider, count stepping and lap control; clear > load > start_stop > lap.
    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        lap_hold_d = lap_hold_q;
        snap_d     = snap_q;
        ld         = 1'b0;
        ld_val     = '0;
        step_up    = 1'b0;
        step_dn    = 1'b0;

        if (bus.clear) begin
            state_d    = StIdle;
            div_d      = '0;
            lap_hold_d = 1'b0;
            ld         = 1'b1;
            ld_val     = '0;
        end else if (bus.load) begin
            state_d    = StIdle;
            div_d      = '0;
            lap_hold_d = 1'b0;
            ld         = 1'b1;
            ld_val     = load_clean;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.start_stop) begin
                        state_d = StRun;
                        div_d   = '0;
                    end
                end
                StRun: begin
                    div_d = tick_now ? '0 : div_q + DIV_W'(1);
                    if (tick_now) begin
                        if (bus.dir) begin
                            if (!at_max) begin
                                step_up = 1'b1;
                            end else if (WRAP_EN) begin
                                step_up = 1'b1;
                            end else begin
                                state_d = StDone;
                            end
                        end else begin
                            if (is_zero) begin
                                state_d = StDone;
                            end else begin
                                step_dn = 1'b1;
                                if (is_one) begin
                                    state_d = StDone;
                                end
                            end
                        end
                    end
                    // A coincident tick is applied first; reaching DONE takes precedence.
                    if (bus.start_stop) begin
                        if (state_d == StRun) begin
                            state_d = StPause;
                        end
                    end else if (bus.lap) begin
                        lap_hold_d = !lap_hold_q;
                        if (!lap_hold_q) begin
                            snap_d = count_w;
                        end
                    end
                end
                StPause: begin
                    // Divider is held so the partial period resumes where it stopped.
                    if (bus.start_stop) begin
                        state_d = StRun;
                    end
                end
                StDone: begin
                    if (bus.start_stop) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Control state registers.
    always_ff @(posedge clk100 or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            div_q      <= '0;
            lap_hold_q <= 1'b0;
            snap_q     <= '0;
            wrap_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            lap_hold_q <= lap_hold_d;
            snap_q     <= snap_d;
            // A carry out of the top digit is exactly the max->0 wrap.
            wrap_q     <= carry[N_DIGITS-1];
        end
    end

    assign bus.count   = count_w;
    assign bus.disp    = lap_hold_q ? snap_q : count_w;
    assign bus.running = (state_q == StRun);
    assign bus.done    = (state_q == StDone);
    assign bus.wrap    = wrap_q;
    assign bus.tick    = tick_now;

endmodule

// File: tb/tb_bcd_stopwatch_core.sv
// Directed bench for bcd_stopwatch_core: two instances (wrap and saturate) share stimulus.
module tb_bcd_stopwatch_core;

    logic        clk100;
    logic        reset_n;
    logic        start_stop;
    logic        clear;
    logic        load;
    logic        dir;
    logic        lap;
    logic [15:0] load_value;

    int n_tests = 0;
    int n_fail  = 0;

    bcd_stopwatch_core_if #(.N_DIGITS(4)) ifa ();
    bcd_stopwatch_core_if #(.N_DIGITS(4)) ifb ();

    assign ifa.start_stop = start_stop;
    assign ifa.clear      = clear;
    assign ifa.load       = load;
    assign ifa.dir        = dir;
    assign ifa.lap        = lap;
    assign ifa.load_value = load_value;
    assign ifb.start_stop = start_stop;
    assign ifb.clear      = clear;
    assign ifb.load       = load;
    assign ifb.dir        = dir;
    assign ifb.lap        = lap;
    assign ifb.load_value = load_value;

    bcd_stopwatch_core #(
        .N_DIGITS      (4),
        .TICK_DIV      (4),
        .TOP_DIGIT_MOD (6),
        .WRAP_EN       (1'b1)
    ) dut_a (
        .clk100  (clk100),
        .reset_n (reset_n),
        .bus     (ifa)
    );

    bcd_stopwatch_core #(
        .N_DIGITS      (4),
        .TICK_DIV      (4),
        .TOP_DIGIT_MOD (6),
        .WRAP_EN       (1'b0)
    ) dut_b (
        .clk100  (clk100),
        .reset_n (reset_n),
        .bus     (ifb)
    );

    initial clk100 = 1'b0;
    always #5 clk100 = ~clk100;

    task automatic tic();
        @(posedge clk100);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%04h expected 0x%04h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        start_stop = 1'b1;
        tic();
        start_stop = 1'b0;
    endtask

    task automatic do_load(input logic [15:0] v);
        load_value = v;
        load       = 1'b1;
        tic();
        load       = 1'b0;
    endtask

    initial begin
        int ticks;
        int phase_err;
        reset_n    = 1'b0;
        start_stop = 1'b0;
        clear      = 1'b0;
        load       = 1'b0;
        dir        = 1'b1;
        lap        = 1'b0;
        load_value = 16'h0000;

        // Reset values
        #2;
        chk("rst_count", ifa.count, 16'h0000);
        chk("rst_disp", ifa.disp, 16'h0000);
        chk("rst_running", 16'(ifa.running), 16'h0);
        chk("rst_done", 16'(ifa.done), 16'h0);
        chk("rst_wrap", 16'(ifa.wrap), 16'h0);
        chk("rst_tick", 16'(ifa.tick), 16'h0);
        #10 reset_n = 1'b1;
        tic();

        // 1. Free run up: tick every 4th cycle, 10 ticks -> 0x0010
        pulse_start();
        chk("t1_running", 16'(ifa.running), 16'h1);
        ticks     = 0;
        phase_err = 0;
        for (int i = 0; i < 40; i++) begin
            if (ifa.tick) ticks++;
            if (ifa.tick !== ((i % 4) == 3)) phase_err++;
            tic();
        end
        chk("t1_tick_count", 16'(ticks), 16'd10);
        chk("t1_tick_phase", 16'(phase_err), 16'd0);
        chk("t1_count", ifa.count, 16'h0010);
        chk("t1_disp", ifa.disp, 16'h0010);
        chk("t1_running2", 16'(ifa.running), 16'h1);

        // 6a. Load sanitising while running; load forces IDLE
        do_load(16'hF7AC);
        chk("t6_sanitise", ifa.count, 16'h5799);
        chk("t6_load_idle", 16'(ifa.running), 16'h0);

        // 2. Wrap at max (dut_a) and saturate into DONE (dut_b)
        do_load(16'h5998);
        pulse_start();
        repeat (3) tic();
        chk("t2_tick", 16'(ifa.tick), 16'h1);
        tic();
        chk("t2_count_max", ifa.count, 16'h5999);
        chk("t2_no_wrap", 16'(ifa.wrap), 16'h0);
        repeat (4) tic();
        chk("t2_wrap_count", ifa.count, 16'h0000);
        chk("t2_wrap_pulse", 16'(ifa.wrap), 16'h1);
        chk("t2_wrap_running", 16'(ifa.running), 16'h1);
        chk("t2_sat_count", ifb.count, 16'h5999);
        chk("t2_sat_done", 16'(ifb.done), 16'h1);
        chk("t2_sat_running", 16'(ifb.running), 16'h0);
        chk("t2_sat_wrap", 16'(ifb.wrap), 16'h0);
        tic();
        chk("t2_wrap_one_cycle", 16'(ifa.wrap), 16'h0);

        // 3. Count down to zero -> DONE on the same edge, no further ticks
        dir = 1'b0;
        do_load(16'h0002);
        pulse_start();
        repeat (4) tic();
        chk("t3_count1", ifa.count, 16'h0001);
        chk("t3_not_done", 16'(ifa.done), 16'h0);
        repeat (4) tic();
        chk("t3_count0", ifa.count, 16'h0000);
        chk("t3_done", 16'(ifa.done), 16'h1);
        chk("t3_stopped", 16'(ifa.running), 16'h0);
        ticks = 0;
        for (int i = 0; i < 8; i++) begin
            if (ifa.tick) ticks++;
            tic();
        end
        chk("t3_no_ticks", 16'(ticks), 16'd0);
        chk("t3_count_hold", ifa.count, 16'h0000);
        // DONE -> IDLE, then down-count started at zero ends on first tick
        pulse_start();
        chk("t3_done_to_idle", 16'({ifa.running, ifa.done}), 16'h0);
        pulse_start();
        repeat (4) tic();
        chk("t3_zero_done", 16'(ifa.done), 16'h1);
        chk("t3_zero_count", ifa.count, 16'h0000);

        // 4. Pause holds the divider; coincident start_stop/tick; dir change
        dir = 1'b1;
        do_load(16'h0003);
        pulse_start();
        tic();
        pulse_start();
        chk("t4_paused", 16'(ifa.running), 16'h0);
        repeat (5) tic();
        chk("t4_pause_tick", 16'(ifa.tick), 16'h0);
        chk("t4_pause_count", ifa.count, 16'h0003);
        pulse_start();
        chk("t4_resume_no_tick", 16'(ifa.tick), 16'h0);
        tic();
        chk("t4_resume_tick", 16'(ifa.tick), 16'h1);
        tic();
        chk("t4_count4", ifa.count, 16'h0004);
        repeat (3) tic();
        chk("t4_tick_again", 16'(ifa.tick), 16'h1);
        pulse_start();
        chk("t4_coinc_count", ifa.count, 16'h0005);
        chk("t4_coinc_pause", 16'(ifa.running), 16'h0);
        dir = 1'b0;
        pulse_start();
        repeat (4) tic();
        chk("t4_dir_down", ifa.count, 16'h0004);

        // 5. Lap hold freezes disp, second lap releases it
        dir = 1'b1;
        do_load(16'h0103);
        pulse_start();
        repeat (8) tic();
        chk("t5_pre_lap", ifa.count, 16'h0105);
        lap = 1'b1;
        tic();
        lap = 1'b0;
        chk("t5_lap_disp", ifa.disp, 16'h0105);
        repeat (8) tic();
        chk("t5_count_moves", ifa.count, 16'h0107);
        chk("t5_disp_frozen", ifa.disp, 16'h0105);
        lap = 1'b1;
        tic();
        lap = 1'b0;
        chk("t5_release", ifa.disp, 16'h0107);
        repeat (2) tic();
        chk("t5_track", ifa.disp, 16'h0108);

        // 6b. clear beats start_stop; async reset mid-RUN
        clear      = 1'b1;
        start_stop = 1'b1;
        tic();
        clear      = 1'b0;
        start_stop = 1'b0;
        chk("t6_clear_count", ifa.count, 16'h0000);
        chk("t6_clear_idle", 16'({ifa.running, ifa.done}), 16'h0);
        chk("t6_clear_disp", ifa.disp, 16'h0000);
        pulse_start();
        repeat (7) tic();
        chk("t6_pre_rst_count", ifa.count, 16'h0001);
        chk("t6_pre_rst_tick", 16'(ifa.tick), 16'h1);
        reset_n = 1'b0;
        #1;
        chk("t6_rst_count", ifa.count, 16'h0000);
        chk("t6_rst_disp", ifa.disp, 16'h0000);
        chk("t6_rst_flags", 16'({ifa.running, ifa.done, ifa.wrap, ifa.tick}), 16'h0);
        #2 reset_n = 1'b1;
        tic();
        chk("t6_post_rst_idle", 16'(ifa.running), 16'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
